// File: rtl/usb_desc_loader_if.sv
// Control, descriptor-ROM and EP0 IN FIFO signals of the descriptor loader.
// master is the loader side; slave is the firmware/ROM/FIFO side.
interface usb_desc_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [15:0]           xfer_len;
  logic [15:0]           req_len;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [7:0]            rom_q;
  logic                  fifo_empty;
  logic                  fifo_wrreq;
  logic [7:0]            fifo_data;
  logic                  zlp_set;

  modport master (
    input  start, src_addr, xfer_len, req_len, abort, rom_q, fifo_empty,
    output busy, done, rom_addr, fifo_wrreq, fifo_data, zlp_set
  );

  modport slave (
    output start, src_addr, xfer_len, req_len, abort, rom_q, fifo_empty,
    input  busy, done, rom_addr, fifo_wrreq, fifo_data, zlp_set
  );
endinterface

// File: rtl/usb_desc_loader.sv
// Streams a ROM descriptor into the EP0 IN FIFO one max-size packet at a time,
// waiting for each packet to drain and arming a ZLP when the transfer needs one.
module usb_desc_loader #(
  parameter int MAX_PACKET = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             usb_reset,
  usb_desc_loader_if.master bus
);
  localparam int CW = $clog2(MAX_PACKET + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PACKET - 1);
  localparam logic [15:0]   MP16     = 16'(MAX_PACKET);

  typedef enum logic [2:0] {IDLE, WAIT, FILL, DRAIN, ZLP, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [15:0]           remain;
  logic [CW-1:0]         pkt_cnt;
  logic                  zlp_need;
  logic                  rd_pend;
  logic                  zlp_r;
  logic                  done_r;

  logic [15:0] eff_len;
  logic        zlp_calc;

  always_comb begin
    eff_len  = (bus.xfer_len < bus.req_len) ? bus.xfer_len : bus.req_len;
    zlp_calc = (bus.req_len != 16'd0) && (eff_len < bus.req_len) &&
               ((eff_len % MP16) == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (usb_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      remain   <= '0;
      pkt_cnt  <= '0;
      zlp_need <= 1'b0;
      rd_pend  <= 1'b0;
      zlp_r    <= 1'b0;
      done_r   <= 1'b0;
    end else if (bus.abort) begin
      state   <= IDLE;
      rd_pend <= 1'b0;
      zlp_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      rd_pend <= 1'b0;
      zlp_r   <= 1'b0;
      done_r  <= 1'b0;
      case (state)
        IDLE: begin
          // done_r still high means the previous transfer is finishing its pulse
          if (bus.start && !done_r) begin
            ptr      <= bus.src_addr;
            remain   <= eff_len;
            zlp_need <= zlp_calc;
            state    <= (bus.req_len == 16'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (bus.fifo_empty) begin
            if (remain != 16'd0) begin
              pkt_cnt <= '0;
              state   <= FILL;
            end else if (zlp_need) begin
              state <= ZLP;
            end else begin
              state <= DONE;
            end
          end
        end
        FILL: begin
          rd_pend <= 1'b1;
          ptr     <= ptr + ADDR_WIDTH'(1);
          remain  <= remain - 16'd1;
          pkt_cnt <= pkt_cnt + CW'(1);
          if (pkt_cnt == LAST_IDX || remain == 16'd1) state <= DRAIN;
        end
        DRAIN: state <= WAIT;
        ZLP: begin
          zlp_r <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM read data arrives the cycle after issue, exactly when rd_pend is seen
  assign bus.rom_addr   = ptr;
  assign bus.fifo_data  = bus.rom_q;
  assign bus.fifo_wrreq = rd_pend & ~bus.abort;
  assign bus.zlp_set    = zlp_r & ~bus.abort;
  assign bus.done       = done_r & ~bus.abort;
  assign bus.busy       = (state != IDLE) || done_r;
endmodule

// File: tb/tb_usb_desc_loader.sv
// Self-checking bench: ROM and EP0 IN FIFO models, monitor logs, per-scenario tasks.
module tb_usb_desc_loader;
  logic clk = 1'b0;
  logic usb_reset;
  always #5 clk = ~clk;

  usb_desc_loader_if #(.ADDR_WIDTH(8)) bus ();
  usb_desc_loader #(.MAX_PACKET(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .usb_reset(usb_reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rom [256];
  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: counts pending bytes, drains a packet after drain_dly idle cycles
  int  fcnt = 0;
  int  dctr = 0;
  int  drain_dly = 0;
  bit  hold = 1'b0;
  assign bus.fifo_empty = (fcnt == 0);

  logic [7:0] wr_q [$];
  logic [7:0] addr_q [$];
  int         wr_cyc_q [$];
  int         pkt_q [$];
  int         zlp_cnt, done_cnt, zlp_cyc, done_cyc, start_cyc;
  logic [7:0] prev_addr = 8'h00;

  always @(negedge clk) begin
    if (bus.fifo_wrreq) begin
      wr_q.push_back(bus.fifo_data);
      addr_q.push_back(prev_addr);
      wr_cyc_q.push_back(cyc);
      fcnt = fcnt + 1;
      dctr = drain_dly;
    end else if (fcnt > 0 && !hold) begin
      if (dctr == 0) begin
        pkt_q.push_back(fcnt);
        fcnt = 0;
      end else begin
        dctr = dctr - 1;
      end
    end
    if (bus.zlp_set) begin zlp_cnt = zlp_cnt + 1; zlp_cyc = cyc; end
    if (bus.done)    begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (bus.start && !bus.busy) start_cyc = cyc;
    prev_addr = bus.rom_addr;
  end

  task automatic clear_log();
    wr_q.delete(); addr_q.delete(); wr_cyc_q.delete(); pkt_q.delete();
    zlp_cnt = 0; done_cnt = 0; zlp_cyc = -1; done_cyc = -1; start_cyc = -1;
  endtask

  task automatic pulse_start(input logic [7:0] src, input logic [15:0] xl, input logic [15:0] rl);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src_addr = src; bus.xfer_len = xl; bus.req_len = rl;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0 && !bus.busy) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: got no done, required done within 3000 cycles", name); end
  endtask

  task automatic test_reset();
    usb_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.done); end
    n_checks++; if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL reset_wrreq: got %b required 0", bus.fifo_wrreq); end
    n_checks++; if (bus.zlp_set !== 1'b0)    begin n_fail++; $display("FAIL reset_zlp: got %b required 0", bus.zlp_set); end
    n_checks++; if (bus.rom_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_rom_addr: got %h required 00", bus.rom_addr); end
    usb_reset = 1'b0;
  endtask

  // Full transfer checked against the length/packet/ZLP rules computed directly
  task automatic test_transfer(input string name, input logic [7:0] src,
                               input logic [15:0] xl, input logic [15:0] rl);
    int L, bad;
    bit zn;
    int exp_pk [$];
    logic [7:0] a;
    L  = (xl < rl) ? int'(xl) : int'(rl);
    zn = (rl != 0) && (L < int'(rl)) && (L % 8 == 0);
    for (int r = L; r > 0; r -= 8) exp_pk.push_back(r < 8 ? r : 8);
    clear_log();
    pulse_start(src, xl, rl);
    wait_idle(name);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (wr_q.size() != L) begin n_fail++; $display("FAIL %s_bytes: got %0d required %0d", name, wr_q.size(), L); end
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < L; i++) begin
      a = src + 8'(i);
      if (wr_q[i] !== rom[a] || addr_q[i] !== a) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_data: got %0d wrong bytes required 0", name, bad); end
    bad = (pkt_q.size() == exp_pk.size()) ? 0 : 1;
    for (int i = 0; i < pkt_q.size() && i < exp_pk.size(); i++) if (pkt_q[i] != exp_pk[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_packets: got %0d packets required %0d (mismatch %0d)", name, pkt_q.size(), exp_pk.size(), bad); end
    n_checks++;
    if (zlp_cnt != int'(zn)) begin n_fail++; $display("FAIL %s_zlp: got %0d required %0d", name, zlp_cnt, zn); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d required 1", name, done_cnt); end
    if (L > 0 && wr_cyc_q.size() > 0) begin
      n_checks++;
      if (wr_cyc_q[0] - start_cyc != 3) begin n_fail++; $display("FAIL %s_first_write: got %0d required 3", name, wr_cyc_q[0] - start_cyc); end
    end
    if (zn) begin
      n_checks++;
      if (done_cyc - zlp_cyc != 1) begin n_fail++; $display("FAIL %s_zlp_to_done: got %0d required 1", name, done_cyc - zlp_cyc); end
    end
    if (rl == 0) begin
      n_checks++;
      if (done_cyc - start_cyc != 2) begin n_fail++; $display("FAIL %s_zero_req_done: got %0d required 2", name, done_cyc - start_cyc); end
    end
  endtask

  task automatic test_backpressure();
    int rel;
    clear_log();
    drain_dly = 0;
    hold = 1'b1;
    pulse_start(8'h20, 16'd16, 16'd16);
    for (int i = 0; i < 100 && wr_q.size() < 8; i++) begin @(posedge clk); #1; end
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (wr_q.size() != 8) begin n_fail++; $display("FAIL hold_no_write: got %0d writes required 8", wr_q.size()); end
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b required 1", bus.busy); end
    hold = 1'b0;
    rel = cyc;
    wait_idle("hold");
    #1;
    n_checks++;
    if (wr_q.size() != 16) begin n_fail++; $display("FAIL hold_bytes: got %0d required 16", wr_q.size()); end
    else begin
      n_checks++;
      if (wr_cyc_q[8] - rel != 2) begin n_fail++; $display("FAIL hold_release: got %0d required 2", wr_cyc_q[8] - rel); end
    end
    n_checks++;
    if (zlp_cnt != 0) begin n_fail++; $display("FAIL hold_zlp: got %0d required 0", zlp_cnt); end
  endtask

  task automatic test_abort();
    clear_log();
    drain_dly = 0;
    pulse_start(8'h10, 16'd18, 16'd64);
    for (int i = 0; i < 200 && wr_q.size() < 11; i++) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    #1;
    n_checks++;
    if (bus.fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL abort_wrreq: got %b required 0", bus.fifo_wrreq); end
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (wr_q.size() != 11) begin n_fail++; $display("FAIL abort_writes: got %0d required 11", wr_q.size()); end
    n_checks++;
    if (zlp_cnt != 0 || done_cnt != 0) begin n_fail++; $display("FAIL abort_pulses: got zlp %0d done %0d required 0 0", zlp_cnt, done_cnt); end
    fcnt = 0;
    test_transfer("after_abort", 8'h40, 16'd10, 16'd64);
  endtask

  task automatic test_wrap_and_busy_start();
    logic [7:0] exp_a;
    int bad;
    clear_log();
    pulse_start(8'hFC, 16'd8, 16'd64);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.src_addr = 8'h40; bus.xfer_len = 16'd3; bus.req_len = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("wrap");
    repeat (3) @(posedge clk);
    #1;
    bad = (addr_q.size() == 8) ? 0 : 1;
    for (int i = 0; i < addr_q.size() && i < 8; i++) begin
      exp_a = 8'hFC + 8'(i);
      if (addr_q[i] !== exp_a) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wrap_addr: got %0d addresses (%0d wrong) required FC..03", addr_q.size(), bad); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d required 1", done_cnt); end
    n_checks++;
    if (zlp_cnt != 1) begin n_fail++; $display("FAIL wrap_zlp: got %0d required 1", zlp_cnt); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      drain_dly = $urandom_range(0, 3);
      test_transfer("random", 8'($urandom), 16'($urandom_range(0, 40)), 16'($urandom_range(0, 48)));
    end
    drain_dly = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    bus.start = 1'b0; bus.abort = 1'b0; bus.src_addr = 8'h00;
    bus.xfer_len = 16'd0; bus.req_len = 16'd0;
    clear_log();
    test_reset();
    test_transfer("len18_req64", 8'h10, 16'd18, 16'd64);
    test_transfer("len16_req255", 8'h80, 16'd16, 16'd255);
    test_transfer("len18_req9", 8'h00, 16'd18, 16'd9);
    test_transfer("len0_req8", 8'h30, 16'd0, 16'd0008);
    test_transfer("req0", 8'h50, 16'd5, 16'd0);
    test_transfer("big_len", 8'hE0, 16'hFFFF, 16'd20);
    test_backpressure();
    test_abort();
    test_wrap_and_busy_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
